alu_rs: RTL

- Reservation station that feeds the execute-stage ALU in the out-of-order pipeline; it is the issuing end of the ALU's grant/operand interface.
- Accepts dispatched ALU ops whose operands may still be pending, and wakes operands from the common data bus (CDB).
- Selects the oldest fully-ready entry, raises a request, and drives a/b/alu_op to the ALU; the entry retires from the station on grant.

---
 rtl/alu_rs.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// ALU reservation station: age-ordered, CDB wakeup, oldest-ready select.
// Optional ALU_RS_STALL_CNT_EN adds a saturating stall_cnt output.
module alu_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [3:0]                 disp_op,
  input  logic [TAG_W-1:0]           disp_dst_tag,
  input  logic                       disp_s1_rdy,
  input  logic                       disp_s2_rdy,
  input  logic [31:0]                disp_s1_val,
  input  logic [31:0]                disp_s2_val,
  input  logic [TAG_W-1:0]           disp_s1_tag,
  input  logic [TAG_W-1:0]           disp_s2_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [31:0]                cdb_value,
  output logic                       issue_req,
  input  logic                       grant,
  output logic [31:0]                a,
  output logic [31:0]                b,
  output logic [3:0]                 alu_op,
  output logic [TAG_W-1:0]           issue_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ALU_RS_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]       op;
    logic [TAG_W-1:0] dst;
    logic             r1;
    logic [31:0]      v1;
    logic [TAG_W-1:0] t1;
    logic             r2;
    logic [31:0]      v2;
    logic [TAG_W-1:0] t2;
  } ent_t;

  ent_t          q [DEPTH];
  ent_t          d [DEPTH];
  ent_t          nw;
  logic          found;
  logic [IW-1:0] sel;
  logic          pop;
  logic          push;
  logic [CW-1:0] cnt_rm;
  logic [CW-1:0] cnt_d;

  assign disp_ready = (count < CW'(DEPTH));

  // Scan from youngest to oldest so the oldest ready entry wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (i < int'(count) && q[i].r1 && q[i].r2) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  assign issue_req = found;
  assign a         = found ? q[sel].v1  : '0;
  assign b         = found ? q[sel].v2  : '0;
  assign alu_op    = found ? q[sel].op  : '0;
  assign issue_tag = found ? q[sel].dst : '0;

  assign pop  = grant && found;
  assign push = disp_valid && disp_ready;

  always_comb begin
    nw.op  = disp_op;
    nw.dst = disp_dst_tag;
    nw.r1  = disp_s1_rdy;
    nw.v1  = disp_s1_val;
    nw.t1  = disp_s1_tag;
    nw.r2  = disp_s2_rdy;
    nw.v2  = disp_s2_val;
    nw.t2  = disp_s2_tag;
    if (!disp_s1_rdy && cdb_valid && disp_s1_tag == cdb_tag) begin
      nw.r1 = 1'b1;
      nw.v1 = cdb_value;
    end
    if (!disp_s2_rdy && cdb_valid && disp_s2_tag == cdb_tag) begin
      nw.r2 = 1'b1;
      nw.v2 = cdb_value;
    end
  end

  // Compact out the granted entry, wake survivors, then append.
  always_comb begin
    d = q;
    if (pop) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        if (i >= int'(sel)) d[i] = q[i+1];
      end
    end
    cnt_rm = count - CW'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && !d[i].r1 && d[i].t1 == cdb_tag) begin
        d[i].r1 = 1'b1;
        d[i].v1 = cdb_value;
      end
      if (cdb_valid && !d[i].r2 && d[i].t2 == cdb_tag) begin
        d[i].r2 = 1'b1;
        d[i].v2 = cdb_value;
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(cnt_rm) == i) d[i] = nw;
      end
    end
    cnt_d = cnt_rm + CW'(push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      count <= cnt_d;
      q     <= d;
    end
  end

`ifdef ALU_RS_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (issue_req && !grant && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
